// File: rtl/serial_add_pkg.sv
// serial_add_pkg -- shared state encoding and width limits for the serial adder. Rev 1.0
`default_nettype none

package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 32;

endpackage

`default_nettype wire

// File: rtl/serial_fa_cell.sv
// serial_fa_cell -- combinational full adder built from two half-adder stages. Rev 1.0
`default_nettype none

module serial_fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);

  logic p;
  logic g1;
  logic g2;

  assign p  = x ^ y;
  assign g1 = x & y;
  assign s  = p ^ cin;
  assign g2 = p & cin;
  assign co = g1 | g2;

endmodule

`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl -- LSB-first bit-serial adder with start/busy/done handshake.
// Defining SERIAL_SUB_EN adds the sub port (two's-complement A-B). Rev 1.0
`default_nettype none

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  import serial_add_pkg::*;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("serial_adder_ctrl: WIDTH out of range");
  end

  state_t           state;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;

  serial_fa_cell u_fa (
    .x   (areg[0]),
    .y   (breg[0]),
    .cin (carry),
    .s   (fa_s),
    .co  (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      areg  <= '0;
      breg  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            areg  <= a;
`ifdef SERIAL_SUB_EN
            breg  <= sub ? ~b : b;
            carry <= sub;
`else
            breg  <= b;
            carry <= 1'b0;
`endif
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          carry <= fa_co;
          areg  <= areg >> 1;
          breg  <= breg >> 1;
          res   <= {fa_s, res[WIDTH-1:1]};
          // The bit produced on the last count completes the word: publish it directly.
          if (cnt == LAST) begin
            sum   <= {fa_s, res[WIDTH-1:1]};
            cout  <= fa_co;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
